// File: rtl/mem_port_sequencer.sv
// Shares a single synchronous RAM port between instruction fetch and execute-stage load/store.
// Optional fetch anti-starvation arbitration is compiled in with `define FETCH_FAIR_EN.
module mem_port_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_valid,
    input  logic [4:0]        op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_done,
    output logic [DATA_W-1:0] load_data,
    output logic              reg_write,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_port_sequencer: RD_LAT must be 1..4 and STARVE_MAX >= 1");
    end

    localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);
    localparam logic [4:0] OP_LOAD   = 5'b11000;
    localparam logic [4:0] OP_STORE  = 5'b11001;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        lat_fetch;
    logic        lat_load;
    logic        lat_store;
    logic        lat_alu_wr;
    logic [2:0]  wait_cnt;
    logic        is_load;
    logic        is_store;
    logic        grant_data;
    logic        grant_fetch;

    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);

`ifdef FETCH_FAIR_EN
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_fetch;

    assign force_fetch = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
    assign grant_data  = mem_valid && !force_fetch;
    assign grant_fetch = if_req && (!mem_valid || force_fetch);

    // Counts IDLE cycles in which a waiting fetch lost to data; saturates at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_fetch) begin
                starve_cnt <= '0;
            end else if (if_req && grant_data && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign grant_data  = mem_valid;
    assign grant_fetch = if_req && !mem_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        mem_done   = 1'b0;
        reg_write  = 1'b0;
        if_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_data) begin
                    state_next = (is_load || is_store) ? ISSUE : RESP;
                end else if (grant_fetch) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                ram_en     = 1'b1;
                ram_we     = lat_store;
                state_next = lat_store ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                mem_done   = !lat_fetch;
                reg_write  = !lat_fetch && (lat_load || lat_alu_wr);
                if_ack     = lat_fetch;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        stall = mem_valid && !mem_done;
    end

    // ram_addr/ram_wdata only move for real RAM accesses so they hold across ALU ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_fetch  <= 1'b0;
            lat_load   <= 1'b0;
            lat_store  <= 1'b0;
            lat_alu_wr <= 1'b0;
            wait_cnt   <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_data    <= '0;
            load_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        lat_fetch  <= 1'b0;
                        lat_load   <= is_load;
                        lat_store  <= is_store;
                        lat_alu_wr <= !op[4];
                        if (is_load || is_store) begin
                            ram_addr <= mem_addr;
                        end
                        if (is_store) begin
                            ram_wdata <= store_data;
                        end
                    end else if (grant_fetch) begin
                        lat_fetch  <= 1'b1;
                        lat_load   <= 1'b1;
                        lat_store  <= 1'b0;
                        lat_alu_wr <= 1'b0;
                        ram_addr   <= if_addr;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == LAST_WAIT) begin
                        if (lat_fetch) begin
                            if_data <= ram_rdata;
                        end else begin
                            load_data <= ram_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: one RD_LAT=1 instance for the main flows and an
// RD_LAT=3 instance for reset during WAIT. Expectations follow FETCH_FAIR_EN when defined.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance a: RD_LAT = 1
    logic        rst, if_req, mem_valid;
    logic [7:0]  if_addr, mem_addr;
    logic [4:0]  op;
    logic [31:0] store_data;
    logic        if_ack, mem_done, reg_write, stall, ram_en, ram_we;
    logic [31:0] if_data, load_data, ram_wdata, ram_rdata;
    logic [7:0]  ram_addr;

    // Instance b: RD_LAT = 3
    logic        b_rst, b_if_req, b_mem_valid;
    logic [7:0]  b_if_addr, b_mem_addr;
    logic [4:0]  b_op;
    logic [31:0] b_store_data;
    logic        b_if_ack, b_mem_done, b_reg_write, b_stall, b_ram_en, b_ram_we;
    logic [31:0] b_if_data, b_load_data, b_ram_wdata, b_ram_rdata;
    logic [7:0]  b_ram_addr;

    mem_port_sequencer #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_data(if_data), .mem_valid(mem_valid), .op(op), .mem_addr(mem_addr),
        .store_data(store_data), .mem_done(mem_done), .load_data(load_data),
        .reg_write(reg_write), .stall(stall), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_sequencer #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(b_rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack),
        .if_data(b_if_data), .mem_valid(b_mem_valid), .op(b_op), .mem_addr(b_mem_addr),
        .store_data(b_store_data), .mem_done(b_mem_done), .load_data(b_load_data),
        .reg_write(b_reg_write), .stall(b_stall), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h30:   return 32'hCAFEF00D;
            8'h40:   return 32'h12345678;
            8'h50:   return 32'hA5A5A5A5;
            default: return 32'h0;
        endcase
    endfunction

    // RAM a: latency 1, writable; unwritten words come from init_word.
    logic [31:0] mem_a   [256];
    logic        written [256];
    logic [31:0] pipe_a;
    initial for (int i = 0; i < 256; i++) written[i] = 1'b0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem_a[ram_addr]   <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                pipe_a <= written[ram_addr] ? mem_a[ram_addr] : init_word(ram_addr);
            end
        end
    end
    assign ram_rdata = pipe_a;

    // RAM b: latency 3, read-only.
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        if (b_ram_en && !b_ram_we) pipe_b[0] <= init_word(b_ram_addr);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_ram_rdata = pipe_b[2];

    int done_a = 0;
    int ack_a  = 0;
    int done_b = 0;
    always @(posedge clk) begin
        if (mem_done)   done_a <= done_a + 1;
        if (if_ack)     ack_a  <= ack_a + 1;
        if (b_mem_done) done_b <= done_b + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int d0, a0, exp_done, exp_ack;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_valid = 1'b0; op = '0;
        mem_addr = '0; store_data = '0;
        b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = '0; b_mem_valid = 1'b0; b_op = '0;
        b_mem_addr = '0; b_store_data = '0;
        step(); step();

        // Reset state
        check("rst_strobes", {if_ack, mem_done, reg_write, ram_en, ram_we, stall}, 0);
        check("rst_if_data", if_data, 0);
        check("rst_load_data", load_data, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        rst = 1'b0; b_rst = 1'b0;
        step();

        // Load 0x10, RD_LAT=1
        mem_valid = 1'b1; op = 5'b11000; mem_addr = 8'h10; #1;
        check("ld_c0_stall", stall, 1);
        check("ld_c0_en", ram_en, 0);
        step();
        check("ld_c1_en_we", {ram_en, ram_we}, 2'b10);
        check("ld_c1_addr", ram_addr, 8'h10);
        check("ld_c1_stall", stall, 1);
        step();
        check("ld_c2_en_done", {ram_en, mem_done}, 2'b00);
        check("ld_c2_stall", stall, 1);
        step();
        check("ld_c3_done_rw", {mem_done, reg_write}, 2'b11);
        check("ld_c3_data", load_data, 32'hDEADBEEF);
        check("ld_c3_stall", stall, 0);
        mem_valid = 1'b0;
        step();
        check("ld_c4_done", mem_done, 0);
        check("ld_c4_hold", load_data, 32'hDEADBEEF);

        // Store 0x55 to 0x20, then load it back
        mem_valid = 1'b1; op = 5'b11001; mem_addr = 8'h20; store_data = 32'h55; #1;
        step();
        check("st_c1_en_we", {ram_en, ram_we}, 2'b11);
        check("st_c1_addr", ram_addr, 8'h20);
        check("st_c1_wdata", ram_wdata, 32'h55);
        step();
        check("st_c2_done_rw_en", {mem_done, reg_write, ram_en}, 3'b100);
        mem_valid = 1'b0;
        step();
        mem_valid = 1'b1; op = 5'b11000; mem_addr = 8'h20; #1;
        step(); step(); step();
        check("ldst_c3_done", mem_done, 1);
        check("ldst_c3_data", load_data, 32'h55);
        mem_valid = 1'b0;
        step();

        // ALU op and unknown op[4]=1 op
        mem_valid = 1'b1; op = 5'b00011; #1;
        check("alu_c0_en", ram_en, 0);
        step();
        check("alu_c1_done_rw_en", {mem_done, reg_write, ram_en}, 3'b110);
        check("alu_c1_stall", stall, 0);
        check("alu_addr_hold", ram_addr, 8'h20);
        mem_valid = 1'b0;
        step();
        mem_valid = 1'b1; op = 5'b11111; #1;
        step();
        check("unk_c1_done_rw_en", {mem_done, reg_write, ram_en}, 3'b100);
        mem_valid = 1'b0;
        step();

        // Contention: data load 0x30 vs fetch 0x40
        a0 = ack_a;
        if_req = 1'b1; if_addr = 8'h40;
        mem_valid = 1'b1; op = 5'b11000; mem_addr = 8'h30; #1;
        step();
        check("ct_c1_addr", ram_addr, 8'h30);
        check("ct_c1_en", ram_en, 1);
        step(); step();
        check("ct_c3_done_ack", {mem_done, if_ack}, 2'b10);
        check("ct_c3_data", load_data, 32'hCAFEF00D);
        mem_valid = 1'b0;
        step();
        check("ct_c4_idle_en", ram_en, 0);
        step();
        check("ct_c5_fetch_issue", {ram_en, ram_we}, 2'b10);
        check("ct_c5_fetch_addr", ram_addr, 8'h40);
        step(); step();
        check("ct_c7_ack_done", {if_ack, mem_done}, 2'b10);
        check("ct_c7_if_data", if_data, 32'h12345678);
        if_req = 1'b0;
        step(); step();
        check("ct_ack_count", ack_a - a0, 1);

        // Starvation: loads every opportunity while fetch stays requested
        d0 = done_a; a0 = ack_a;
        if_req = 1'b1; if_addr = 8'h40;
        mem_valid = 1'b1; op = 5'b11000; mem_addr = 8'h10;
        repeat (24) step();
`ifdef FETCH_FAIR_EN
        exp_done = 5; exp_ack = 1;
`else
        exp_done = 6; exp_ack = 0;
`endif
        check("sv_done_count", done_a - d0, exp_done);
        check("sv_ack_count", ack_a - a0, exp_ack);
        if_req = 1'b0; mem_valid = 1'b0;
        step(); step();

        // Reset during WAIT on the RD_LAT=3 instance
        b_mem_valid = 1'b1; b_op = 5'b11000; b_mem_addr = 8'h50; #1;
        step();
        check("rb_c1_en", b_ram_en, 1);
        check("rb_c1_addr", b_ram_addr, 8'h50);
        step();
        b_rst = 1'b1;
        d0 = done_b;
        step();
        check("rb_c3_strobes", {b_ram_en, b_ram_we, b_mem_done, b_reg_write, b_if_ack}, 0);
        check("rb_c3_stall", b_stall, 1);
        check("rb_c3_load_data", b_load_data, 0);
        check("rb_c3_if_data", b_if_data, 0);
        check("rb_c3_ram_addr", b_ram_addr, 0);
        check("rb_c3_ram_wdata", b_ram_wdata, 0);
        b_rst = 1'b0;
        step();
        check("rb_c4_reissue", {b_ram_en, b_ram_addr}, {1'b1, 8'h50});
        step(); step();
        check("rb_c6_no_done", b_mem_done, 0);
        step();
        check("rb_c7_no_done", b_mem_done, 0);
        step();
        check("rb_c8_done_rw", {b_mem_done, b_reg_write}, 2'b11);
        check("rb_c8_data", b_load_data, 32'hA5A5A5A5);
        check("rb_no_early_done", done_b - d0, 0);
        b_mem_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
